// File: rtl/timer_ctrl_if.sv
// Control/status bundle between a timer_ctrl instance and whatever sequences it.
interface timer_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic             stop;
    logic             pause;
    logic             mode;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, stop, pause, mode, period,
        input  count, busy, done, err
    );

    modport slave (
        input  start, stop, pause, mode, period,
        output count, busy, done, err
    );
endinterface

// File: rtl/timer_ctrl.sv
// Period timer with one-shot / auto-reload modes, pause and abort.
// state | meaning
// IDLE  | waiting for start; count parked at 0 (or unchanged after err)
// RUN   | counting one step per edge toward period_q-1
// HOLD  | paused, count frozen; resume edge does not increment
module timer_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             terminal;

    assign terminal = (count_q == period_q - WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.period != '0) begin
                        period_d = bus.period;
                        mode_d   = bus.mode;
                        count_d  = '0;
                        state_d  = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // stop beats pause beats terminal/increment
                if (bus.stop) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (bus.pause) begin
                    state_d = HOLD;
                end else if (terminal) begin
                    count_d = '0;
                    done_d  = 1'b1;
                    state_d = mode_q ? RUN : IDLE;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            HOLD: begin
                if (bus.stop) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (!bus.pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule
